// File: rtl/uart_debug_responder_if.sv
// Byte-side uart, CPU PC tap and debug bus signals of the host command responder.
// master is the responder; slave is the uart/bus/CPU environment around it.
interface uart_debug_responder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_re;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [31:0] pc_in;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    input  pc_in, bus_rdata, bus_ack,
    output rx_re, tx_data, tx_we,
    output bus_addr, bus_wdata,
    output bus_rd, bus_wr, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    output pc_in, bus_rdata, bus_ack,
    input  rx_re, tx_data, tx_we,
    input  bus_addr, bus_wdata,
    input  bus_rd, bus_wr, busy
  );
endinterface

// File: rtl/uart_debug_responder.sv
// Host byte-command responder: PC snapshot, debug bus read/write,
// big-endian replies through the uart byte interface.
module uart_debug_responder #(
  parameter int BUS_TIMEOUT = 255,
  parameter int RX_TIMEOUT  = 500000
) (
  input  logic clk,
  input  logic rst,
  uart_debug_responder_if.master io
);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARGS, BUS, SEND} state_t;

  state_t        state, state_nx;
  logic          is_wr;
  logic [2:0]    arg_cnt;
  logic [2:0]    tx_left;
  logic [1:0]    guard;
  logic [31:0]   reply;
  logic [31:0]   addr_q, wdata_q;
  logic [BW-1:0] bus_cnt;
  logic [RW-1:0] idle_cnt;
  logic          rx_re_q, tx_we_q;
  logic [7:0]    tx_data_q;

  logic take, arg_last, bus_tmo, rx_tmo, tx_go;
  logic op_p, op_r, op_w;

  assign take = (state == IDLE || state == ARGS)
              && io.rx_valid && !rx_re_q;
  assign op_p = io.rx_data == 8'h50;
  assign op_r = io.rx_data == 8'h52;
  assign op_w = io.rx_data == 8'h57;
  assign arg_last = take && state == ARGS
                 && arg_cnt == (is_wr ? 3'd7 : 3'd3);
  assign bus_tmo = bus_cnt == BW'(BUS_TIMEOUT - 1);
  assign rx_tmo  = idle_cnt == RW'(RX_TIMEOUT - 1);
  assign tx_go = state == SEND && guard == 2'd0
              && tx_left != 3'd0 && !io.tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take) state_nx = (op_r || op_w) ? ARGS : SEND;
      ARGS: begin
        if (arg_last)           state_nx = BUS;
        else if (!take && rx_tmo) state_nx = IDLE;
      end
      BUS:  if (io.bus_ack || bus_tmo) state_nx = SEND;
      SEND: if (guard == 2'd1 && tx_left == 3'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    io.busy   = state != IDLE;
    io.bus_rd = state == BUS && !is_wr;
    io.bus_wr = state == BUS && is_wr;
  end

  assign io.rx_re     = rx_re_q;
  assign io.tx_we     = tx_we_q;
  assign io.tx_data   = tx_data_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_re_q   <= 1'b0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
      is_wr     <= 1'b0;
      arg_cnt   <= '0;
      tx_left   <= '0;
      guard     <= '0;
      reply     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      rx_re_q <= take;
      tx_we_q <= tx_go;
      if (tx_go) tx_data_q <= reply[31:24];
      unique case (state)
        IDLE: begin
          arg_cnt  <= '0;
          idle_cnt <= '0;
          bus_cnt  <= '0;
          guard    <= '0;
          if (take) begin
            unique case (1'b1)
              op_p: begin
                reply   <= io.pc_in;
                tx_left <= 3'd4;
              end
              op_r, op_w: is_wr <= op_w;
              default: begin
                reply   <= {8'h3F, 24'd0};
                tx_left <= 3'd1;
              end
            endcase
          end
        end
        ARGS: begin
          if (take) begin
            arg_cnt  <= arg_cnt + 3'd1;
            idle_cnt <= '0;
            // first four bytes are the address, the rest the write data
            if (arg_cnt[2]) wdata_q <= {wdata_q[23:0], io.rx_data};
            else            addr_q  <= {addr_q[23:0], io.rx_data};
          end else if (!rx_tmo) begin
            idle_cnt <= idle_cnt + RW'(1);
          end
        end
        BUS: begin
          if (io.bus_ack) begin
            reply   <= is_wr ? {8'h4B, 24'd0} : io.bus_rdata;
            tx_left <= is_wr ? 3'd1 : 3'd4;
          end else if (bus_tmo) begin
            reply   <= {8'hEE, 24'd0};
            tx_left <= 3'd1;
          end else begin
            bus_cnt <= bus_cnt + BW'(1);
          end
        end
        SEND: begin
          // guard spans the tx_we cycle plus two cycles of busy-flag latency
          if (tx_go) begin
            reply   <= {reply[23:0], 8'd0};
            tx_left <= tx_left - 3'd1;
            guard   <= 2'd3;
          end else if (guard != 2'd0) begin
            guard <= guard - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_debug_responder.sv
// Scoreboarded bench for uart_debug_responder: directed host commands,
// uart and debug-bus models, reply bytes checked by a tx monitor.
module tb_uart_debug_responder;
  localparam int RXT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_debug_responder_if io();

  uart_debug_responder #(
    .BUS_TIMEOUT(255),
    .RX_TIMEOUT(RXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // uart transmitter model
  int busy_len = 3;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (io.tx_we)          busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign io.tx_busy = busy_cnt != 0;

  // debug bus model: ack on the ack_delay-th request cycle (0 = never)
  int ack_delay = 0;
  logic [31:0] rdata_v = '0;
  logic stray = 1'b0;
  int req_cyc = 0;
  int rd_hi = 0;
  int wr_hi = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_wdata = '0;
  logic addr_moved = 1'b0;
  assign io.bus_rdata = rdata_v;
  always @(negedge clk) begin
    if (io.bus_rd || io.bus_wr) begin
      if (req_cyc == 0) begin
        seen_addr  = io.bus_addr;
        seen_wdata = io.bus_wdata;
      end else if (io.bus_addr !== seen_addr ||
                   io.bus_wdata !== seen_wdata) begin
        addr_moved = 1'b1;
      end
      req_cyc++;
      if (io.bus_rd) rd_hi++;
      if (io.bus_wr) wr_hi++;
      io.bus_ack = ack_delay != 0 && req_cyc == ack_delay;
    end else begin
      req_cyc = 0;
      io.bus_ack = stray;
    end
  end

  // tx monitor / scoreboard
  int we_cnt = 0;
  always @(negedge clk) begin
    if (io.tx_we) begin
      we_cnt++;
      check("tx_busy_at_we", {31'd0, io.tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %h expected none",
                 io.tx_data);
      end else begin
        check("tx_byte", {24'd0, io.tx_data},
              {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    io.rx_data  = b;
    io.rx_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!io.rx_re && n < 50);
    if (!io.rx_re) begin
      tests++;
      fails++;
      $display("FAIL rx_accept: byte %h got no rx_re expected pulse", b);
    end
    io.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic push(input logic [7:0] b[$]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (io.busy && n < lim);
    if (io.busy) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within %0d", lim);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, k, w0, r0, wr0;
    io.rx_data  = '0;
    io.rx_valid = 1'b0;
    io.pc_in    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_re", {31'd0, io.rx_re}, 0);
    check("rst_tx_we", {31'd0, io.tx_we}, 0);
    check("rst_tx_data", {24'd0, io.tx_data}, 0);
    check("rst_bus_req", {30'd0, io.bus_rd, io.bus_wr}, 0);
    check("rst_bus_addr", io.bus_addr, 0);
    check("rst_bus_wdata", io.bus_wdata, 0);
    check("rst_busy", {31'd0, io.busy}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // 1: PC snapshot against a slow transmitter
    busy_len = 100;
    io.pc_in = 32'h0000_1234;
    push('{8'h00, 8'h00, 8'h12, 8'h34});
    w0 = we_cnt;
    send_byte(8'h50);
    io.pc_in = 32'hFFFF_FFFF;
    k = 0;
    n = 0;
    while (k < 4 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (io.tx_we) k++;
    end
    wait_idle(20, n);
    check("p_guard_tail", n, 3);
    check("p_we_pulses", we_cnt - w0, 4);
    check("p_reply_done", exp_q.size(), 0);
    busy_len = 3;

    // 2: bus read, ack on third request cycle
    ack_delay = 3;
    rdata_v = 32'hDEAD_BEEF;
    r0 = rd_hi;
    push('{8'hDE, 8'hAD, 8'hBE, 8'hEF});
    send_cmd('{8'h52, 8'h00, 8'h00, 8'h00, 8'h10});
    wait_idle(500, n);
    check("r_addr", seen_addr, 32'h10);
    check("r_rd_cycles", rd_hi - r0, 3);
    check("r_reply_done", exp_q.size(), 0);

    // 3: bus write, ack on first cycle
    ack_delay = 1;
    wr0 = wr_hi;
    r0 = rd_hi;
    push('{8'h4B});
    send_cmd('{8'h57, 8'h00, 8'h00, 8'h00, 8'h20,
               8'h00, 8'h00, 8'h00, 8'hA5});
    wait_idle(500, n);
    check("w_addr", seen_addr, 32'h20);
    check("w_wdata", seen_wdata, 32'hA5);
    check("w_wr_cycles", wr_hi - wr0, 1);
    check("w_no_rd", rd_hi - r0, 0);
    check("w_reply_done", exp_q.size(), 0);

    // 4: bus read timeout, then a stray ack while idle
    ack_delay = 0;
    r0 = rd_hi;
    push('{8'hEE});
    send_cmd('{8'h52, 8'h00, 8'h00, 8'h00, 8'h04});
    wait_idle(1000, n);
    check("rt_addr", seen_addr, 32'h04);
    check("rt_rd_cycles", rd_hi - r0, 255);
    check("rt_reply_done", exp_q.size(), 0);
    w0 = we_cnt;
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stray_ack_busy", {31'd0, io.busy}, 0);
    check("stray_ack_no_tx", we_cnt - w0, 0);

    // 4b: ack on the timeout cycle wins
    ack_delay = 255;
    rdata_v = 32'hCAFE_F00D;
    r0 = rd_hi;
    push('{8'hCA, 8'hFE, 8'hF0, 8'h0D});
    send_cmd('{8'h52, 8'h00, 8'h00, 8'h01, 8'h00});
    wait_idle(1000, n);
    check("ra_addr", seen_addr, 32'h100);
    check("ra_rd_cycles", rd_hi - r0, 255);
    check("ra_reply_done", exp_q.size(), 0);
    check("bus_addr_stable", {31'd0, addr_moved}, 0);

    // 5: unknown opcode, argument timeout, recovery
    push('{8'h3F});
    send_byte(8'h41);
    wait_idle(100, n);
    check("unk_reply_done", exp_q.size(), 0);
    w0 = we_cnt;
    send_cmd('{8'h52, 8'h00, 8'h00});
    wait_idle(RXT + 50, n);
    check("rx_timeout_cycles", n, RXT);
    check("rx_timeout_no_tx", we_cnt - w0, 0);
    io.pc_in = 32'hA5A5_0001;
    push('{8'hA5, 8'hA5, 8'h00, 8'h01});
    send_byte(8'h50);
    wait_idle(200, n);
    check("post_tmo_reply_done", exp_q.size(), 0);

    // 6: reset in the middle of a reply
    io.pc_in = 32'h1122_3344;
    push('{8'h11, 8'h22, 8'h33, 8'h44});
    send_byte(8'h50);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!io.tx_we && n < 100);
    check("pre_rst_tx_we", {31'd0, io.tx_we}, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx_we", {31'd0, io.tx_we}, 0);
    check("mid_rst_rx_re", {31'd0, io.rx_re}, 0);
    check("mid_rst_bus_rd", {31'd0, io.bus_rd}, 0);
    check("mid_rst_busy", {31'd0, io.busy}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    io.pc_in = 32'h0BAD_C0DE;
    push('{8'h0B, 8'hAD, 8'hC0, 8'hDE});
    send_byte(8'h50);
    wait_idle(200, n);
    check("post_rst_reply_done", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
